// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
//
// One processing element of a systolic MAC array. It can run in two modes:
//   mode=0  weight-stationary : the partial sum from the north gets
//                               in_act*weight added and goes on south.
//   mode=1  output-stationary : in_act*weight builds up in a local
//                               accumulator, which is emitted on drain.
// Activations always go east with one cycle of latency.
// Weights are double buffered. w_load fills a shadow register, and w_swap
// moves the shadow into the active weight. A swap is only used by beats
// that are accepted on the edges after the swap edge.
//
// Build option:
//   SYSTOLIC_PE_SAT_EN  defined   -> accumulator/psum additions saturate and
//                                    set the sticky 'sat' flag
//                       undefined -> additions wrap modulo 2^ACC_W, sat = 0
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   in_valid           activation/psum beat qualifier
//   in_act, in_psum    activation from the west, partial sum from the north
//   w_load, w_data     write the shadow weight register
//   w_swap             move shadow -> active when the shadow is full
//   mode, drain        dataflow select; OS-only accumulator drain
//   out_valid          qualifies out_psum
//   out_act            registered activation to the east
//   out_psum           registered partial sum / drained result to the south
//   w_full             shadow holds a weight that has not been swapped yet
//   sat                sticky overflow flag
// -----------------------------------------------------------------------------
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_act,
    input  logic signed [ACC_W-1:0]  in_psum,
    input  logic                     w_load,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     w_swap,
    input  logic                     mode,
    input  logic                     drain,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_act,
    output logic signed [ACC_W-1:0]  out_psum,
    output logic                     w_full,
    output logic                     sat
);

    logic signed [DATA_W-1:0]   active_w_reg;
    logic signed [DATA_W-1:0]   shadow_w_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic                       mode_reg;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    ws_sum;
    logic signed [ACC_W-1:0]    os_sum;
    logic                       mode_change;
    logic                       swap_ok;

    // The full-precision product always fits in ACC_W (ACC_W >= 2*DATA_W).
    // A signed cast to the wider width sign-extends it.
    assign prod        = in_act * active_w_reg;
    assign prod_ext    = ACC_W'(prod);
    assign mode_change = (mode != mode_reg);
    assign swap_ok     = w_swap & w_full;

`ifdef SYSTOLIC_PE_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] ws_full;
    logic signed [ACC_W:0] os_full;
    logic                  ws_ovf;
    logic                  os_ovf;
    logic                  sat_reg;

    // Add with one guard bit. Overflow has happened when the guard bit and
    // the MSB of the result differ. The guard bit is the true sign, so it
    // decides which rail to clamp to.
    assign ws_full = {in_psum[ACC_W-1], in_psum} + {prod_ext[ACC_W-1], prod_ext};
    assign os_full = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};
    assign ws_ovf  = ws_full[ACC_W] ^ ws_full[ACC_W-1];
    assign os_ovf  = os_full[ACC_W] ^ os_full[ACC_W-1];
    assign ws_sum  = ws_ovf ? (ws_full[ACC_W] ? ACC_MIN : ACC_MAX) : ws_full[ACC_W-1:0];
    assign os_sum  = os_ovf ? (os_full[ACC_W] ? ACC_MIN : ACC_MAX) : os_full[ACC_W-1:0];
    assign sat     = sat_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_reg <= 1'b0;
        end else if (!mode_change && in_valid) begin
            // Only additions whose result is actually stored count. A drain
            // reloads acc with the bare product, so it adds nothing.
            if (!mode && ws_ovf)
                sat_reg <= 1'b1;
            else if (mode && !drain && os_ovf)
                sat_reg <= 1'b1;
        end
    end
`else
    assign ws_sum = in_psum + prod_ext;
    assign os_sum = acc_reg + prod_ext;
    assign sat    = 1'b0;
`endif

    // Weight double buffer. If load and swap come together, the active
    // weight takes the old shadow value and the shadow takes the new data.
    // w_full then stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_w_reg <= '0;
            shadow_w_reg <= '0;
            w_full       <= 1'b0;
        end else begin
            if (swap_ok)
                active_w_reg <= shadow_w_reg;
            if (w_load)
                shadow_w_reg <= w_data;
            if (w_load)
                w_full <= 1'b1;
            else if (swap_ok)
                w_full <= 1'b0;
        end
    end

    // Datapath. mode_reg holds the mode seen at the previous edge. When it
    // differs from the current mode, that edge is a flush: the accumulator
    // and out_valid are cleared and the beat on the inputs is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg  <= 1'b0;
            acc_reg   <= '0;
            out_act   <= '0;
            out_psum  <= '0;
            out_valid <= 1'b0;
        end else begin
            mode_reg <= mode;
            if (mode_change) begin
                acc_reg   <= '0;
                out_valid <= 1'b0;
            end else if (!mode) begin
                // Weight-stationary: the psum passes through with a MAC added.
                if (in_valid) begin
                    out_act   <= in_act;
                    out_psum  <= ws_sum;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                // Output-stationary: accumulate locally and emit on drain.
                if (in_valid)
                    out_act <= in_act;
                if (drain) begin
                    out_psum  <= acc_reg;
                    out_valid <= 1'b1;
                    acc_reg   <= in_valid ? prod_ext : '0;
                end else begin
                    out_valid <= 1'b0;
                    if (in_valid)
                        acc_reg <= os_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe
//
// Self-checking bench for systolic_pe with DATA_W=8 and ACC_W=16.
// A table of weight-stationary vectors is run first. Hand-written sequences
// then cover double buffering, swap timing, output-stationary accumulate and
// drain, mode-change flush, saturation/wrap, and asynchronous reset.
// Expected out_psum values are pushed to a queue when a beat is driven. A
// monitor pops and compares them whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_systolic_pe;

    localparam int DW = 8;
    localparam int AW = 16;
`ifdef SYSTOLIC_PE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] in_act;
    logic signed [AW-1:0] in_psum;
    logic                 w_load;
    logic signed [DW-1:0] w_data;
    logic                 w_swap;
    logic                 mode;
    logic                 drain;
    logic                 out_valid;
    logic signed [DW-1:0] out_act;
    logic signed [AW-1:0] out_psum;
    logic                 w_full;
    logic                 sat;

    systolic_pe #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_act   (in_act),
        .in_psum  (in_psum),
        .w_load   (w_load),
        .w_data   (w_data),
        .w_swap   (w_swap),
        .mode     (mode),
        .drain    (drain),
        .out_valid(out_valid),
        .out_act  (out_act),
        .out_psum (out_psum),
        .w_full   (w_full),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    int vec_count = 0;
    int err_count = 0;
    logic signed [AW-1:0] exp_q[$];

    typedef struct {
        int w;
        int act;
        int psum;
        int exp_psum;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] required);
        vec_count++;
        if (actual !== required) begin
            err_count++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Reference for one ACC_W addition: the exact sum, then clamped or
    // wrapped to 16 bits depending on the build.
    function automatic int model(input int psum, input int act, input int w);
        int s;
        logic signed [AW-1:0] t;
        s = psum + act * w;
        if (SAT_ON) begin
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            return s;
        end
        t = s[AW-1:0];
        return int'(t);
    endfunction

    // Scoreboard monitor: every valid output must match the oldest expected value.
    always @(posedge clk) begin
        #1;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                err_count++;
                $display("FAIL unexpected_out_valid: got out_psum %0d, expected no output (t=%0t)",
                         out_psum, $time);
            end else begin
                check("out_psum", out_psum, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int w);
        w_load = 1'b1;
        w_data = DW'(w);
        tick();
        w_load = 1'b0;
    endtask

    task automatic swap();
        w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
    endtask

    task automatic beat_ws(input int act, input int psum, input int expv);
        in_valid = 1'b1;
        in_act   = DW'(act);
        in_psum  = AW'(psum);
        exp_q.push_back(AW'(expv));
        tick();
        in_valid = 1'b0;
        check("ws_out_valid", out_valid, 1);
        check("ws_out_act", out_act, act);
    endtask

    task automatic drain_os(input bit v, input int act, input int expv);
        drain    = 1'b1;
        in_valid = v;
        in_act   = DW'(act);
        exp_q.push_back(AW'(expv));
        tick();
        drain    = 1'b0;
        in_valid = 1'b0;
        check("drain_out_valid", out_valid, 1);
    endtask

    initial begin
        vecs[0] = '{w: 3,    act: -4,   psum: 100,    exp_psum: 88};
        vecs[1] = '{w: -5,   act: 7,    psum: 0,      exp_psum: -35};
        vecs[2] = '{w: 127,  act: 127,  psum: 0,      exp_psum: 16129};
        vecs[3] = '{w: -128, act: -128, psum: 0,      exp_psum: 16384};
        vecs[4] = '{w: -128, act: 127,  psum: -100,   exp_psum: -16356};
        vecs[5] = '{w: 0,    act: 55,   psum: -1234,  exp_psum: -1234};
        vecs[6] = '{w: 1,    act: -1,   psum: 1,      exp_psum: 0};
        vecs[7] = '{w: -2,   act: 3,    psum: -32000, exp_psum: -32006};

        reset = 1'b1; in_valid = 1'b0; in_act = '0; in_psum = '0;
        w_load = 1'b0; w_data = '0; w_swap = 1'b0; mode = 1'b0; drain = 1'b0;
        #2;
        check("rst_out_act", out_act, 0);
        check("rst_out_psum", out_psum, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_w_full", w_full, 0);
        check("rst_sat", sat, 0);
        tick();
        reset = 1'b0;
        tick();

        // Weight-stationary table
        for (int i = 0; i < 8; i++) begin
            load_w(vecs[i].w);
            check("w_full_set", w_full, 1);
            check("idle_out_valid", out_valid, 0);
            swap();
            check("w_full_clr", w_full, 0);
            beat_ws(vecs[i].act, vecs[i].psum, vecs[i].exp_psum);
        end

        // Double buffer: load+swap together, then swap with an empty shadow
        load_w(2); swap(); load_w(7);
        w_load = 1'b1; w_data = 8'sd5; w_swap = 1'b1;
        tick();
        w_load = 1'b0; w_swap = 1'b0;
        check("dbuf_w_full", w_full, 1);
        beat_ws(1, 0, 7);
        swap();
        check("dbuf_w_full_after_swap", w_full, 0);
        beat_ws(1, 0, 5);
        swap();
        check("dbuf_empty_swap_w_full", w_full, 0);
        beat_ws(1, 0, 5);
        // A swap on the same edge as a beat must not affect that beat
        load_w(9);
        w_swap = 1'b1;
        beat_ws(1, 0, 5);
        w_swap = 1'b0;
        beat_ws(1, 0, 9);

        // Output-stationary accumulate and drain
        load_w(2); swap();
        mode = 1'b1;
        tick();
        check("os_mode_chg_valid", out_valid, 0);
        for (int a = 1; a <= 3; a++) begin
            in_valid = 1'b1; in_act = DW'(a);
            tick();
            check("os_acc_valid", out_valid, 0);
            check("os_out_act", out_act, a);
        end
        in_valid = 1'b0;
        drain_os(1'b0, 0, 12);
        tick();
        check("os_valid_one_cycle", out_valid, 0);
        drain_os(1'b0, 0, 0);
        drain_os(1'b1, 4, 0);
        drain_os(1'b0, 0, 8);
        // Mode change with a beat present: flush, beat dropped
        in_valid = 1'b1; in_act = 8'sd5;
        tick();
        mode = 1'b0; in_act = -8'sd9; in_psum = '0;
        tick();
        in_valid = 1'b0;
        check("mode_chg_valid", out_valid, 0);
        check("mode_chg_act_held", out_act, 5);
        mode = 1'b1;
        tick();
        drain_os(1'b0, 0, 0);

        // Saturation or wrap
        mode = 1'b0;
        tick();
        load_w(1); swap();
        check("sat_before", sat, 0);
        beat_ws(1, 32767, model(32767, 1, 1));
        check("sat_pos", sat, SAT_ON);
        beat_ws(-1, -32768, model(-32768, -1, 1));
        check("sat_neg", sat, SAT_ON);

        // Asynchronous reset during OS accumulation (acc = 10)
        mode = 1'b1;
        tick();
        load_w(1); swap();
        in_valid = 1'b1; in_act = 8'sd5;
        tick(); tick();
        in_valid = 1'b0;
        load_w(3);
        check("pre_rst_w_full", w_full, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_act", out_act, 0);
        check("arst_out_psum", out_psum, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_w_full", w_full, 0);
        check("arst_sat", sat, 0);
        tick();
        reset = 1'b0;
        tick();
        drain_os(1'b1, 5, 0);
        drain_os(1'b0, 0, 0);

        tick(); tick();
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
